// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants for the ADC result path
package adc_pkg;

    localparam int ADC_RESULT_W       = 10;
    localparam int ADC_FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/adc_fifo_mem.sv
// rtl/adc_fifo_mem.sv - DEPTH x DATA_W register array, one write port, one registered read port
module adc_fifo_mem #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The array itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_result_fifo.sv
// rtl/adc_result_fifo.sv - ADC result capture FIFO; optional level IRQ under ADC_FIFO_IRQ_EN
module adc_result_fifo
    import adc_pkg::*;
#(
    parameter int DATA_W  = ADC_RESULT_W,
    parameter int DEPTH   = ADC_FIFO_DEPTH_DEF,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              conv_done_in,
    input  logic              clear_in,
    input  logic              rd_en_in,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_valid_out,
    output logic              empty_out,
    output logic              full_out,
    output logic [LVL_W-1:0]  level_out,
    output logic              overflow_out,
    input  logic [LVL_W-1:0]  threshold_in,
    output logic              irq_out
);

    localparam int PW = LVL_W - 1;

    logic             conv_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic             wr_stb;
    logic             rd_ok;
    logic             wr_ok;

    assign wr_stb = conv_done_in & ~conv_q & enable_in;
    assign rd_ok  = rd_en_in & ~empty_out & ~clear_in;
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign wr_ok  = wr_stb & (~full_out | rd_ok) & ~clear_in;

    always_comb begin
        level_next = level;
        if (clear_in) begin
            level_next = '0;
        end else if (wr_ok && !rd_ok) begin
            level_next = level + LVL_W'(1);
        end else if (rd_ok && !wr_ok) begin
            level_next = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_q       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow_out <= 1'b0;
            rd_valid_out <= 1'b0;
        end else begin
            conv_q       <= conv_done_in;
            level        <= level_next;
            rd_valid_out <= rd_ok;
            if (clear_in) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                overflow_out <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (wr_stb && !wr_ok) begin
                    overflow_out <= 1'b1;
                end
            end
        end
    end

    assign level_out = level;
    assign empty_out = (level == '0);
    assign full_out  = (level == LVL_W'(DEPTH));

    adc_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data_out)
    );

`ifdef ADC_FIFO_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_out <= 1'b0;
        end else begin
            irq_out <= (level_next >= threshold_in) && (threshold_in != '0);
        end
    end
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold_in;
    assign irq_out          = 1'b0;
`endif

endmodule

// File: tb/tb_adc_result_fifo.sv
// tb/tb_adc_result_fifo.sv - directed self-checking bench for adc_result_fifo
module tb_adc_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable_in;
    logic [9:0] data_in;
    logic       conv_done_in;
    logic       clear_in;
    logic       rd_en_in;
    logic [9:0] rd_data_out;
    logic       rd_valid_out;
    logic       empty_out;
    logic       full_out;
    logic [4:0] level_out;
    logic       overflow_out;
    logic [4:0] threshold_in;
    logic       irq_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adc_result_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_in    (enable_in),
        .data_in      (data_in),
        .conv_done_in (conv_done_in),
        .clear_in     (clear_in),
        .rd_en_in     (rd_en_in),
        .rd_data_out  (rd_data_out),
        .rd_valid_out (rd_valid_out),
        .empty_out    (empty_out),
        .full_out     (full_out),
        .level_out    (level_out),
        .overflow_out (overflow_out),
        .threshold_in (threshold_in),
        .irq_out      (irq_out)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [9:0] d);
        data_in      = d;
        conv_done_in = 1'b1;
        tick();
        conv_done_in = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    task automatic test_reset();
        do_write(10'h011);
        do_write(10'h022);
        do_write(10'h033);
        checks++; if (level_out !== 5'd3) begin errors++; $display("FAIL reset_prefill_level got=%0d exp=3", level_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({empty_out, level_out, overflow_out, rd_valid_out, full_out, irq_out} !== {1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0})
            begin errors++; $display("FAIL reset_outputs got e=%b l=%0d o=%b v=%b f=%b i=%b exp e=1 l=0 o=0 v=0 f=0 i=0",
                                     empty_out, level_out, overflow_out, rd_valid_out, full_out, irq_out); end
        checks++; if (rd_data_out !== 10'h000) begin errors++; $display("FAIL reset_rd_data got=%h exp=000", rd_data_out); end
        tick();
        rst_n = 1'b1;
        rd_en_in = 1'b1;
        tick();
        rd_en_in = 1'b0;
        checks++; if (rd_valid_out !== 1'b0) begin errors++; $display("FAIL reset_no_pop_valid got=%b exp=0", rd_valid_out); end
        tick();
        checks++; if (empty_out !== 1'b1 || level_out !== 5'd0) begin errors++; $display("FAIL reset_after got e=%b l=%0d exp e=1 l=0", empty_out, level_out); end
    endtask

    task automatic test_order();
        logic [9:0] vals [3];
        vals[0] = 10'h001; vals[1] = 10'h3FF; vals[2] = 10'h155;
        data_in      = 10'h001;
        conv_done_in = 1'b1;
        tick();
        checks++; if (empty_out !== 1'b0) begin errors++; $display("FAIL order_latency_empty got=%b exp=0", empty_out); end
        conv_done_in = 1'b0;
        tick();
        do_write(vals[1]);
        do_write(vals[2]);
        for (int i = 0; i < 3; i++) begin
            rd_en_in = 1'b1;
            tick();
            rd_en_in = 1'b0;
            checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== vals[i])
                begin errors++; $display("FAIL order_pop%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid_out, rd_data_out, vals[i]); end
            tick();
            checks++; if (rd_valid_out !== 1'b0) begin errors++; $display("FAIL order_pulse%0d got=%b exp=0", i, rd_valid_out); end
        end
        checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL order_empty got=%b exp=1", empty_out); end
        rd_en_in = 1'b1;
        tick();
        rd_en_in = 1'b0;
        checks++; if (rd_valid_out !== 1'b0 || rd_data_out !== 10'h155)
            begin errors++; $display("FAIL order_empty_pop got v=%b d=%h exp v=0 d=155", rd_valid_out, rd_data_out); end
    endtask

    task automatic test_edge_detect();
        data_in      = 10'h0F0;
        conv_done_in = 1'b1;
        repeat (5) tick();
        conv_done_in = 1'b0;
        tick();
        checks++; if (level_out !== 5'd1) begin errors++; $display("FAIL edge_hold_level got=%0d exp=1", level_out); end
        do_clear();
        enable_in    = 1'b0;
        conv_done_in = 1'b1;
        repeat (2) tick();
        enable_in = 1'b1;
        repeat (3) tick();
        conv_done_in = 1'b0;
        tick();
        checks++; if (level_out !== 5'd0) begin errors++; $display("FAIL edge_enable_late got=%0d exp=0", level_out); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) do_write(10'(10'h100 + i));
        checks++; if (full_out !== 1'b1 || overflow_out !== 1'b0)
            begin errors++; $display("FAIL ovf_full got f=%b o=%b exp f=1 o=0", full_out, overflow_out); end
        do_write(10'h2AA);
        checks++; if (full_out !== 1'b1 || overflow_out !== 1'b1 || level_out !== 5'd16)
            begin errors++; $display("FAIL ovf_drop got f=%b o=%b l=%0d exp f=1 o=1 l=16", full_out, overflow_out, level_out); end
        for (int i = 0; i < 16; i++) begin
            rd_en_in = 1'b1;
            tick();
            rd_en_in = 1'b0;
            checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 10'(10'h100 + i))
                begin errors++; $display("FAIL ovf_pop%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid_out, rd_data_out, 10'(10'h100 + i)); end
        end
        tick();
        checks++; if (empty_out !== 1'b1 || overflow_out !== 1'b1)
            begin errors++; $display("FAIL ovf_drained got e=%b o=%b exp e=1 o=1", empty_out, overflow_out); end
        do_clear();
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow_out); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) do_write(10'(10'h010 + i));
        data_in      = 10'h0AB;
        conv_done_in = 1'b1;
        rd_en_in     = 1'b1;
        tick();
        conv_done_in = 1'b0;
        rd_en_in     = 1'b0;
        checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 10'h010 || level_out !== 5'd16 || overflow_out !== 1'b0)
            begin errors++; $display("FAIL b2b_full got v=%b d=%h l=%0d o=%b exp v=1 d=010 l=16 o=0",
                                     rd_valid_out, rd_data_out, level_out, overflow_out); end
        for (int i = 1; i < 16; i++) begin
            rd_en_in = 1'b1;
            tick();
            checks++; if (rd_data_out !== 10'(10'h010 + i))
                begin errors++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, rd_data_out, 10'(10'h010 + i)); end
        end
        tick();
        rd_en_in = 1'b0;
        checks++; if (rd_valid_out !== 1'b1 || rd_data_out !== 10'h0AB)
            begin errors++; $display("FAIL b2b_last got v=%b d=%h exp v=1 d=0ab", rd_valid_out, rd_data_out); end
        tick();
        checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL b2b_drained got=%b exp=1", empty_out); end
        data_in      = 10'h055;
        conv_done_in = 1'b1;
        rd_en_in     = 1'b1;
        tick();
        conv_done_in = 1'b0;
        rd_en_in     = 1'b0;
        checks++; if (level_out !== 5'd1 || rd_valid_out !== 1'b0)
            begin errors++; $display("FAIL b2b_empty got l=%0d v=%b exp l=1 v=0", level_out, rd_valid_out); end
        tick();
        do_clear();
    endtask

    task automatic test_irq();
        threshold_in = 5'd4;
`ifdef ADC_FIFO_IRQ_EN
        for (int i = 0; i < 3; i++) do_write(10'(i));
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_below got=%b exp=0", irq_out); end
        data_in      = 10'h004;
        conv_done_in = 1'b1;
        tick();
        conv_done_in = 1'b0;
        checks++; if (level_out !== 5'd4 || irq_out !== 1'b1)
            begin errors++; $display("FAIL irq_reach got l=%0d i=%b exp l=4 i=1", level_out, irq_out); end
        tick();
        rd_en_in = 1'b1;
        tick();
        rd_en_in = 1'b0;
        checks++; if (level_out !== 5'd3 || irq_out !== 1'b0)
            begin errors++; $display("FAIL irq_drop got l=%0d i=%b exp l=3 i=0", level_out, irq_out); end
        do_clear();
        threshold_in = 5'd0;
        for (int i = 0; i < 5; i++) begin
            do_write(10'(i));
            checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_thr0_%0d got=%b exp=0", i, irq_out); end
        end
`else
        for (int i = 0; i < 6; i++) begin
            do_write(10'(i));
            checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_off_%0d got=%b exp=0", i, irq_out); end
        end
`endif
        do_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        enable_in    = 1'b1;
        data_in      = '0;
        conv_done_in = 1'b0;
        clear_in     = 1'b0;
        rd_en_in     = 1'b0;
        threshold_in = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_order();
        test_edge_detect();
        test_overflow();
        test_back_to_back();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
